// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, run-gated write strobes and the 4-bit ALU control code.
module mips_multicycle_control #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       instr_retired,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t cur_state;
    state_t nxt_state;
    logic   run;
    logic   funct_ok;
    logic   pc_en_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            run       <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            run       <= 1'b1;
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state     = cur_state;
        alu_control   = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_en_c       = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_en_c    = mem_ready;
                // The run-gated first cycle fetches nothing, so it must not advance either.
                if (mem_ready && run) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:        nxt_state = funct_ok ? S_EXEC : S_ILLEGAL;
                    6'h23, 6'h2B: nxt_state = S_MEMADR;
                    6'h04, 6'h05: nxt_state = S_BRANCH;
                    6'h08:        nxt_state = S_ADDIEX;
                    6'h02:        nxt_state = S_JUMP;
                    default:      nxt_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord       = 1'b1;
                if (mem_ready) nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c   = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord        = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    nxt_state     = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h22:   alu_control = ALU_SUB;
                    6'h24:   alu_control = ALU_AND;
                    6'h25:   alu_control = ALU_OR;
                    6'h2A:   alu_control = ALU_SLT;
                    6'h27:   alu_control = ALU_NOR;
                    default: alu_control = ALU_ADD;
                endcase
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c   = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_control   = ALU_SUB;
                pc_source     = 2'b01;
                pc_en_c       = (opcode == 6'h05) ? ~zero : zero;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_JUMP: begin
                pc_source     = 2'b10;
                pc_en_c       = 1'b1;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c   = 1'b1;
                instr_retired = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
                nxt_state     = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    assign pc_en     = pc_en_c & run;
    assign ir_write  = ir_write_c & run;
    assign reg_write = reg_write_c & run;
    assign mem_read  = mem_read_c & run;
    assign mem_write = mem_write_c & run;
    assign state     = cur_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM; a second instance runs with ILLEGAL_HALT=1.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n, rst_h;
    logic [5:0] opcode, funct, opcode_h;
    logic       zero, mem_ready;

    logic [3:0] alu_control, state;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       pc_en, ir_write, reg_write, mem_read, mem_write;
    logic       iord, reg_dst, mem_to_reg, instr_retired, illegal_instr;

    logic [3:0] alu_control_h, state_h;
    logic       alu_src_a_h;
    logic [1:0] alu_src_b_h, pc_source_h;
    logic       pc_en_h, ir_write_h, reg_write_h, mem_read_h, mem_write_h;
    logic       iord_h, reg_dst_h, mem_to_reg_h, instr_retired_h, illegal_instr_h;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr)
    );

    mips_multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_h), .opcode(opcode_h), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(alu_control_h), .alu_src_a(alu_src_a_h),
        .alu_src_b(alu_src_b_h), .pc_source(pc_source_h), .pc_en(pc_en_h),
        .ir_write(ir_write_h), .reg_write(reg_write_h), .mem_read(mem_read_h),
        .mem_write(mem_write_h), .iord(iord_h), .reg_dst(reg_dst_h),
        .mem_to_reg(mem_to_reg_h), .state(state_h),
        .instr_retired(instr_retired_h), .illegal_instr(illegal_instr_h)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] strobes();
        return {pc_en, ir_write, reg_write, mem_read, mem_write};
    endfunction

    initial begin
        logic [5:0] fn_tab [5];
        logic [3:0] ac_tab [5];
        logic [5:0] br_op  [4];
        logic       br_z   [4];
        logic       br_pc  [4];

        fn_tab = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        ac_tab = '{4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
        br_op  = '{6'h04, 6'h04, 6'h05, 6'h05};
        br_z   = '{1'b1, 1'b0, 1'b1, 1'b0};
        br_pc  = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; rst_h = 1'b0;
        opcode = 6'h00; funct = 6'h20; opcode_h = 6'h3F;
        zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_state", state, 4'd0);
        chk("reset_strobes", strobes(), 5'b0);
        chk("reset_alu_default", alu_control, 4'b0010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst_h = 1'b1;
        #1;
        chk("run_gate_state", state, 4'd0);
        chk("run_gate_strobes", strobes(), 5'b0);

        // R-type add
        tick();
        chk("fetch_state", state, 4'd0);
        chk("fetch_strobes", strobes(), 5'b11010);
        chk("fetch_srcb", alu_src_b, 2'b01);
        tick();
        chk("decode_state", state, 4'd1);
        chk("decode_srcb", alu_src_b, 2'b11);
        chk("decode_retired", instr_retired, 1'b0);
        tick();
        chk("exec_state", state, 4'd6);
        chk("exec_add", alu_control, 4'b0010);
        chk("exec_srca", alu_src_a, 1'b1);
        tick();
        chk("aluwb_state", state, 4'd7);
        chk("aluwb_regwrite", reg_write, 1'b1);
        chk("aluwb_regdst", reg_dst, 1'b1);
        chk("aluwb_retired", instr_retired, 1'b1);
        chk("halt_inst_illegal", state_h, 4'd12);
        tick();
        chk("r_back_to_fetch", state, 4'd0);

        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            tick();
            tick();
            chk("r_funct_state", state, 4'd6);
            chk("r_funct_aluctl", alu_control, ac_tab[i]);
            tick();
            tick();
        end

        // Illegal funct
        funct = 6'h3F;
        tick();
        tick();
        chk("illfn_state", state, 4'd12);
        chk("illfn_flag", illegal_instr, 1'b1);
        chk("illfn_strobes", strobes(), 5'b0);
        chk("illfn_retired", instr_retired, 1'b0);
        tick();
        chk("illfn_to_fetch", state, 4'd0);
        chk("illfn_flag_clr", illegal_instr, 1'b0);

        // lw with two wait cycles in MEMRD
        opcode = 6'h23; funct = 6'h20;
        tick();
        chk("lw_decode", state, 4'd1);
        tick();
        chk("lw_memadr", state, 4'd2);
        chk("lw_memadr_srcb", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        tick();
        chk("lw_memrd1", state, 4'd3);
        chk("lw_memrd_read", mem_read, 1'b1);
        chk("lw_memrd_iord", iord, 1'b1);
        tick();
        chk("lw_memrd2", state, 4'd3);
        tick();
        chk("lw_memrd3", state, 4'd3);
        mem_ready = 1'b1;
        tick();
        chk("lw_memwb", state, 4'd4);
        chk("lw_memtoreg", mem_to_reg, 1'b1);
        chk("lw_regwrite", reg_write, 1'b1);
        chk("lw_retired", instr_retired, 1'b1);
        tick();
        chk("lw_to_fetch", state, 4'd0);

        // beq/bne with both zero values
        for (int i = 0; i < 4; i++) begin
            opcode = br_op[i];
            zero   = br_z[i];
            tick();
            tick();
            chk("br_state", state, 4'd8);
            chk("br_pcen", pc_en, br_pc[i]);
            chk("br_pcsrc", pc_source, 2'b01);
            chk("br_aluctl", alu_control, 4'b0110);
            chk("br_retired", instr_retired, 1'b1);
            tick();
        end
        zero = 1'b0;

        // j
        opcode = 6'h02;
        tick();
        tick();
        chk("j_state", state, 4'd9);
        chk("j_pcen", pc_en, 1'b1);
        chk("j_pcsrc", pc_source, 2'b10);
        tick();

        // addi
        opcode = 6'h08;
        tick();
        tick();
        chk("addi_ex", state, 4'd10);
        chk("addi_srcb", alu_src_b, 2'b10);
        tick();
        chk("addi_wb", state, 4'd11);
        chk("addi_regwrite", reg_write, 1'b1);
        chk("addi_regdst", reg_dst, 1'b0);
        chk("addi_retired", instr_retired, 1'b1);
        tick();

        // sw completing normally
        opcode = 6'h2B;
        tick();
        tick();
        tick();
        chk("sw_memwr", state, 4'd5);
        chk("sw_write", mem_write, 1'b1);
        chk("sw_retired", instr_retired, 1'b1);
        tick();
        chk("sw_to_fetch", state, 4'd0);

        // sw stalled, then aborted by async reset
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("swab_memwr", state, 4'd5);
        chk("swab_write", mem_write, 1'b1);
        chk("swab_noretire", instr_retired, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("swab_rst_state", state, 4'd0);
        chk("swab_rst_write", mem_write, 1'b0);
        chk("swab_rst_retired", instr_retired, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerun_gate", strobes(), 5'b0);

        // halting instance must still be parked in ILLEGAL
        chk("halt_still_illegal", state_h, 4'd12);
        chk("halt_flag", illegal_instr_h, 1'b1);
        chk("halt_retired", instr_retired_h, 1'b0);
        #1 rst_h = 1'b0;
        #1;
        chk("halt_async_rst", state_h, 4'd0);
        chk("halt_flag_clr", illegal_instr_h, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
